ccff_bitstream_loader: RTL and testbench

Loads a configuration bitstream into the fabric's configuration flip-flop chain. It accepts fixed-width words from the SoC/host side over a valid/ready stream and serializes them MSB-first onto `ccff_head` of the first tile in the chain (the IO tile chain). It drives `config_enable` for the whole programming session and qualifies every shifted bit with a chain clock enable. It sits directly upstream of the grid tiles' `ccff_head` input, in the `prog_clk` domain.

---
 rtl/ccff_loader_pkg.sv | 24 ++
 rtl/ccff_crc8_serial.sv | 36 +++
 rtl/ccff_bitstream_loader.sv | 212 +++++++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared types and helpers for the configuration-chain loader.
//   ccff_ld_state_t : loader FSM state encoding (CHECK is only reached when
//                     CCFF_LOADER_CRC_CHECK_EN is defined)
//   CCFF_CRC8_POLY  : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   crc8_step()     : advance a CRC-8 by one serial bit
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } ccff_ld_state_t;

  localparam logic [7:0] CCFF_CRC8_POLY = 8'h07;

  // MSB-first serial CRC-8 update, matching the order bits enter the chain.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CCFF_CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// ccff_crc8_serial: running CRC-8 over the bits clocked into the chain.
//   prog_clk  : programming clock
//   pReset_n  : asynchronous active-low reset
//   clr_i     : synchronous clear to the initial value 0x00
//   bit_en_i  : a chain bit is captured this cycle
//   bit_i     : the chain bit being captured
//   crc_o     : current CRC value
module ccff_crc8_serial
  import ccff_loader_pkg::*;
(
  input  logic       prog_clk,
  input  logic       pReset_n,
  input  logic       clr_i,
  input  logic       bit_en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  // CRC register: cleared per session, advanced once per enabled chain bit.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      crc_q <= 8'h00;
    end else if (clr_i) begin
      crc_q <= 8'h00;
    end else if (bit_en_i) begin
      crc_q <= crc8_step(crc_q, bit_i);
    end else begin
      crc_q <= crc_q;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises host words MSB-first into the fabric's
// configuration flip-flop chain.
//   prog_clk, pReset_n     : programming clock, async active-low reset
//   start                  : begins a session (only honoured in IDLE)
//   s_data/s_valid/s_ready : input word stream
//   ccff_head              : serial data into the chain
//   chain_clk_en           : chain captures ccff_head on this edge
//   config_enable          : high for the whole session
//   busy, done, error      : status (done is a one-cycle pulse, error sticky)
// Optional feature macro: CCFF_LOADER_CRC_CHECK_EN adds a CHECK state that
// accepts one trailing word and compares its low byte to a CRC-8 of the
// shifted bits.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int SH_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [SH_W-1:0]  FULL_CNT = SH_W'(WORD_W);

  ccff_ld_state_t    state_q;
  logic [WORD_W-1:0] hold_q;
  logic              hold_full_q;
  logic [WORD_W-1:0] sh_q;
  logic [SH_W-1:0]   sh_cnt_q;     // bits still to emit from sh_q
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              ccff_head_q;
  logic              chain_clk_en_q;
  logic              config_enable_q;
  logic              done_q;

  logic              s_ready_s;
  logic              accept_s;
  logic              have_bit_s;
  logic              from_hold_s;
  logic              direct_s;
  logic [WORD_W-1:0] src_word_s;
  logic [SH_W-1:0]   src_cnt_s;

`ifdef CCFF_LOADER_CRC_CHECK_EN
  logic       error_q;
  logic [7:0] crc_s;
  logic       crc_clr_s;

  assign crc_clr_s = (state_q == ST_IDLE) && start;

  // The CRC follows the registered chain outputs, so it covers exactly the
  // bits the chain captured, in capture order.
  ccff_crc8_serial u_crc (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .clr_i    (crc_clr_s),
    .bit_en_i (chain_clk_en_q),
    .bit_i    (ccff_head_q),
    .crc_o    (crc_s)
  );

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Ready: space in the holding register during LOAD, or the CRC word slot.
  always_comb begin
    s_ready_s = 1'b0;
    case (state_q)
      ST_LOAD:  s_ready_s = !hold_full_q;
`ifdef CCFF_LOADER_CRC_CHECK_EN
      ST_CHECK: s_ready_s = 1'b1;
`endif
      default:  s_ready_s = 1'b0;
    endcase
  end

  assign accept_s = s_valid && s_ready_s;

  // Next-bit source: shift register, then holding register, then a word
  // accepted this very cycle (bypass keeps first-bit latency at one cycle).
  always_comb begin
    have_bit_s  = 1'b0;
    from_hold_s = 1'b0;
    direct_s    = 1'b0;
    src_word_s  = '0;
    src_cnt_s   = '0;
    if ((state_q == ST_LOAD) && (bit_cnt_q != LAST_CNT)) begin
      if (sh_cnt_q != '0) begin
        have_bit_s = 1'b1;
        src_word_s = sh_q;
        src_cnt_s  = sh_cnt_q;
      end else if (hold_full_q) begin
        have_bit_s  = 1'b1;
        from_hold_s = 1'b1;
        src_word_s  = hold_q;
        src_cnt_s   = FULL_CNT;
      end else if (accept_s) begin
        have_bit_s = 1'b1;
        direct_s   = 1'b1;
        src_word_s = s_data;
        src_cnt_s  = FULL_CNT;
      end else begin
        have_bit_s = 1'b0;
      end
    end else begin
      have_bit_s = 1'b0;
    end
  end

  // Loader FSM, datapath and registered outputs.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q         <= ST_IDLE;
      hold_q          <= '0;
      hold_full_q     <= 1'b0;
      sh_q            <= '0;
      sh_cnt_q        <= '0;
      bit_cnt_q       <= '0;
      ccff_head_q     <= 1'b0;
      chain_clk_en_q  <= 1'b0;
      config_enable_q <= 1'b0;
      done_q          <= 1'b0;
`ifdef CCFF_LOADER_CRC_CHECK_EN
      error_q         <= 1'b0;
`endif
    end else begin
      chain_clk_en_q <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q         <= ST_LOAD;
            bit_cnt_q       <= '0;
            hold_full_q     <= 1'b0;
            sh_cnt_q        <= '0;
            config_enable_q <= 1'b1;
`ifdef CCFF_LOADER_CRC_CHECK_EN
            error_q         <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          // ccff_head keeps its last value when no bit is available.
          if (have_bit_s) begin
            ccff_head_q    <= src_word_s[WORD_W-1];
            chain_clk_en_q <= 1'b1;
            sh_q           <= src_word_s << 1;
            sh_cnt_q       <= src_cnt_s - SH_W'(1);
            bit_cnt_q      <= bit_cnt_q + CNT_W'(1);
          end
          if (accept_s && !direct_s) begin
            hold_q      <= s_data;
            hold_full_q <= 1'b1;
          end else if (from_hold_s) begin
            hold_full_q <= 1'b0;
          end
          // Chain full: leftover word bits are dropped.
          if (bit_cnt_q == LAST_CNT) begin
            hold_full_q <= 1'b0;
            sh_cnt_q    <= '0;
`ifdef CCFF_LOADER_CRC_CHECK_EN
            state_q     <= ST_CHECK;
`else
            state_q         <= ST_FINISH;
            config_enable_q <= 1'b0;
            done_q          <= 1'b1;
`endif
          end
        end
`ifdef CCFF_LOADER_CRC_CHECK_EN
        ST_CHECK: begin
          if (accept_s) begin
            error_q         <= (s_data[7:0] != crc_s);
            state_q         <= ST_FINISH;
            config_enable_q <= 1'b0;
            done_q          <= 1'b1;
          end
        end
`endif
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready       = s_ready_s;
  assign ccff_head     = ccff_head_q;
  assign chain_clk_en  = chain_clk_en_q;
  assign config_enable = config_enable_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
module tb_ccff_bitstream_loader;
  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;

  logic              prog_clk = 1'b0;
  logic              pReset_n = 1'b0;
  logic              start    = 1'b0;
  logic [WORD_W-1:0] s_data   = '0;
  logic              s_valid  = 1'b0;
  logic              s_ready, ccff_head, chain_clk_en, config_enable, busy, done, error;

  ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .chain_clk_en(chain_clk_en),
    .config_enable(config_enable), .busy(busy), .done(done), .error(error)
  );

  always #5 prog_clk = ~prog_clk;

  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  logic exp_q[$];
  int   pushed, en_cnt, run, max_run, first_en_cyc, last_en_cyc, held_off, acc0;
  logic [7:0] crc_model;
  logic last_head = 1'b0;

  always @(posedge prog_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard consumer: every enabled chain bit is popped and compared.
  always @(negedge prog_clk) begin
    if (chain_clk_en === 1'b1) begin
      en_cnt++;
      run++;
      if (run > max_run) max_run = run;
      last_en_cyc = cyc;
      if (first_en_cyc < 0) first_en_cyc = cyc;
      chk("bit_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("chain_bit", ccff_head, exp_q.pop_front());
    end else begin
      run = 0;
      if (busy === 1'b1) chk("head_hold", ccff_head, last_head);
    end
    if (s_valid === 1'b1 && s_ready === 1'b0 && busy === 1'b1) held_off++;
    last_head = ccff_head;
  end

  task automatic clear_stats();
    exp_q.delete();
    pushed = 0; en_cnt = 0; run = 0; max_run = 0;
    first_en_cyc = -1; last_en_cyc = -1; held_off = 0; crc_model = 8'h00;
  endtask

  // Scoreboard producer: the first CHAIN_LEN bits, MSB first, plus their CRC.
  task automatic push_word(input logic [7:0] w);
    logic fb;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (pushed < CHAIN_LEN) begin
        exp_q.push_back(w[i]);
        fb = crc_model[7] ^ w[i];
        crc_model = {crc_model[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        pushed++;
      end
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit push);
    int k;
    s_data = w; s_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge prog_clk);
      if (s_ready === 1'b1) break;
    end
    chk("accept_timeout", (k < 200), 1);
    @(posedge prog_clk); #1;
    if (push) push_word(w);
    s_valid = 1'b0;
  endtask

  // Pulse start, then offer the first word from cycle 1 onward.
  task automatic start_session(input logic [7:0] w0);
    clear_stats();
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    s_data = w0; s_valid = 1'b1;
    @(negedge prog_clk);
    chk("c1_config_enable", config_enable, 1);
    chk("c1_s_ready", s_ready, 1);
    chk("c1_busy", busy, 1);
    chk("c1_error", error, 0);
    acc0 = cyc;
    @(posedge prog_clk); #1;
    push_word(w0);
    s_valid = 1'b0;
  endtask

  task automatic end_session(input logic [7:0] crc_flip);
    int k;
`ifdef CCFF_LOADER_CRC_CHECK_EN
    for (k = 0; k < 200; k++) begin
      @(negedge prog_clk);
      if (en_cnt >= CHAIN_LEN) break;
    end
    chk("bits_timeout", (k < 200), 1);
    @(posedge prog_clk); #1;
    send_word(crc_model ^ crc_flip, 1'b0);
`endif
    for (k = 0; k < 200; k++) begin
      @(negedge prog_clk);
      if (done === 1'b1) break;
    end
    chk("done_timeout", (k < 200), 1);
    chk("cfg_en_falls_with_done", config_enable, 0);
    chk("error_at_done", error, (crc_flip != 8'h00));
`ifndef CCFF_LOADER_CRC_CHECK_EN
    chk("done_latency", cyc, last_en_cyc + 1);
`endif
    @(negedge prog_clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after", busy, 0);
    chk("enabled_bits", en_cnt, CHAIN_LEN);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    clear_stats();
    // Reset state
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_ccff_head", ccff_head, 0);
    chk("rst_chain_clk_en", chain_clk_en, 0);
    chk("rst_config_enable", config_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(posedge prog_clk); #1 pReset_n = 1'b1;

    // Basic back-to-back load
    start_session(8'hA5);
    send_word(8'h3C, 1'b1);
    send_word(8'hF0, 1'b1);
    chk("first_bit_latency", first_en_cyc, acc0 + 1);
    end_session(8'h00);
    chk("basic_contiguous", max_run, CHAIN_LEN);

    // Long input gap forces underflow; bits must still match
    start_session(8'hA5);
    repeat (12) @(posedge prog_clk);
    #1;
    send_word(8'h3C, 1'b1);
    send_word(8'hF0, 1'b1);
    end_session(8'h00);
    chk("stall_longest_run", max_run, 12);

    // Backpressure with s_valid held high from cycle 1
    start_session(8'h5A);
    send_word(8'hC3, 1'b1);
    send_word(8'h0F, 1'b1);
    chk("backpressure_seen", (held_off > 0), 1);
    end_session(8'h00);

    // start during LOAD is ignored
    start_session(8'hA5);
    start = 1'b1;
    send_word(8'h3C, 1'b1);
    start = 1'b0;
    send_word(8'hF0, 1'b1);
    end_session(8'h00);
    chk("start_ignored_run", max_run, CHAIN_LEN);

    // Reset after 7 enabled bits, then a fresh session
    start_session(8'hA5);
    for (k = 0; k < 200; k++) begin
      @(negedge prog_clk);
      if (en_cnt >= 7) break;
    end
    chk("seven_bits_timeout", (k < 200), 1);
    #2 pReset_n = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_ccff_head", ccff_head, 0);
    chk("mid_rst_chain_clk_en", chain_clk_en, 0);
    chk("mid_rst_config_enable", config_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    @(posedge prog_clk); #1 pReset_n = 1'b1;
    start_session(8'h96);
    send_word(8'h69, 1'b1);
    send_word(8'hFF, 1'b1);
    end_session(8'h00);

`ifdef CCFF_LOADER_CRC_CHECK_EN
    // Corrupted CRC sets error; next start clears it
    start_session(8'hA5);
    send_word(8'h3C, 1'b1);
    send_word(8'hF0, 1'b1);
    end_session(8'h01);
    chk("error_sticky", error, 1);
    start_session(8'hA5);
    send_word(8'h3C, 1'b1);
    send_word(8'hF0, 1'b1);
    end_session(8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
